// File: rtl/ula_ncl_pkg.sv
// Shared types for the dual-rail ALU stage: rail codes, op codes, FSM states.
package ula_ncl_pkg;

   localparam logic [1:0] NCL_NULL = 2'b00;
   localparam logic [1:0] NCL_D0   = 2'b01;
   localparam logic [1:0] NCL_D1   = 2'b10;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_XOR = 2'b10,
      OP_OR  = 2'b11
   } op_e;

   typedef enum logic {
      S_NULL = 1'b0,
      S_DATA = 1'b1
   } state_e;

   function automatic logic [1:0] ncl_enc(input logic v);
      return v ? NCL_D1 : NCL_D0;
   endfunction

endpackage

// File: rtl/ula_ncl_seq_completion.sv
// Completion detector for one dual-rail vector of N pairs: complete / null / illegal.
module ncl_completion #(
   parameter int N             = 1,
   parameter bit CHECK_ILLEGAL = 1'b0
) (
   input  logic [2*N-1:0] rails,
   output logic           complete,
   output logic           is_null,
   output logic           illegal
);

   always_comb begin
      complete = 1'b1;
      is_null  = 1'b1;
      illegal  = 1'b0;
      for (int k = 0; k < N; k++) begin
         complete = complete & (rails[2*k+1] | rails[2*k]);
         is_null  = is_null & ~(rails[2*k+1] | rails[2*k]);
         illegal  = illegal | (rails[2*k+1] & rails[2*k]);
      end
      // An 11 pair is plain logic 1 when checking is off, so never report it.
      if (!CHECK_ILLEGAL) illegal = 1'b0;
   end

endmodule

// File: rtl/ula_ncl_seq.sv
// Clocked dual-rail ALU stage with four-phase DATA/NULL handshake.
// Build option: ULA_ILLEGAL_CHECK_EN blocks on 11 pairs and raises a sticky err.
//
// state  | meaning
// S_NULL | outputs all NULL, ko=1, waiting for complete inputs with ki=1
// S_DATA | outputs hold registered result, ko=0, waiting for null inputs with ki=0
module ula_ncl_seq
   import ula_ncl_pkg::*;
#(
   parameter int WIDTH = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [2*WIDTH-1:0] a,
   input  logic [2*WIDTH-1:0] b,
   input  logic [1:0]         sel0,
   input  logic [1:0]         sel1,
   input  logic [1:0]         carry_in,
   input  logic               ki,
   output logic               ko,
   output logic [2*WIDTH-1:0] out,
   output logic [1:0]         overflow,
   output logic [1:0]         carry_out,
   output logic [1:0]         neg,
   output logic [1:0]         zero,
   output logic               err
);

   localparam int NP = 2*WIDTH + 3;
   localparam int MSB = WIDTH - 1;
`ifdef ULA_ILLEGAL_CHECK_EN
   localparam bit CHECK = 1'b1;
`else
   localparam bit CHECK = 1'b0;
`endif

   state_e           state_q, state_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             ovf_q, ovf_d;
   logic             cy_q, cy_d;

   logic             in_complete, in_null, in_illegal, load;
   logic [WIDTH-1:0] a_v, b_v, b_op, res_c;
   logic [WIDTH:0]   sum;
   logic             cin, ovf_c, cy_c;
   op_e              op;

   ncl_completion #(.N(NP), .CHECK_ILLEGAL(CHECK)) u_comp (
      .rails    ({carry_in, sel1, sel0, b, a}),
      .complete (in_complete),
      .is_null  (in_null),
      .illegal  (in_illegal)
   );

   // The true rail alone carries the bit value, so 11 reads as logic 1.
   always_comb begin
      a_v = '0;
      b_v = '0;
      for (int k = 0; k < WIDTH; k++) begin
         a_v[k] = a[2*k+1];
         b_v[k] = b[2*k+1];
      end
      op   = op_e'({sel1[1], sel0[1]});
      cin  = carry_in[1];
      b_op = (op == OP_SUB) ? ~b_v : b_v;
      sum  = {1'b0, a_v} + {1'b0, b_op} + {{WIDTH{1'b0}}, cin};
      res_c = sum[WIDTH-1:0];
      ovf_c = 1'b0;
      cy_c  = 1'b0;
      case (op)
         OP_ADD: begin
            cy_c  = sum[WIDTH];
            ovf_c = (a_v[MSB] == b_v[MSB]) && (res_c[MSB] != a_v[MSB]);
         end
         OP_SUB: begin
            cy_c  = sum[WIDTH];
            ovf_c = (a_v[MSB] != b_v[MSB]) && (res_c[MSB] == b_v[MSB]);
         end
         OP_XOR: res_c = a_v ^ b_v;
         default: res_c = a_v | b_v;
      endcase
   end

   assign load = (state_q == S_NULL) && in_complete && !in_illegal && ki;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_NULL;
         res_q   <= '0;
         ovf_q   <= 1'b0;
         cy_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         res_q   <= res_d;
         ovf_q   <= ovf_d;
         cy_q    <= cy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      res_d   = load ? res_c : res_q;
      ovf_d   = load ? ovf_c : ovf_q;
      cy_d    = load ? cy_c  : cy_q;
      case (state_q)
         S_NULL:  if (load) state_d = S_DATA;
         S_DATA:  if (in_null && !ki) state_d = S_NULL;
         default: state_d = S_NULL;
      endcase
   end

   always_comb begin
      ko        = 1'b1;
      out       = '0;
      overflow  = NCL_NULL;
      carry_out = NCL_NULL;
      neg       = NCL_NULL;
      zero      = NCL_NULL;
      if (state_q == S_DATA) begin
         ko = 1'b0;
         for (int k = 0; k < WIDTH; k++) out[2*k +: 2] = ncl_enc(res_q[k]);
         overflow  = ncl_enc(ovf_q);
         carry_out = ncl_enc(cy_q);
         neg       = ncl_enc(res_q[MSB]);
         zero      = ncl_enc(res_q == '0);
      end
   end

`ifdef ULA_ILLEGAL_CHECK_EN
   logic err_q, err_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_q <= 1'b0;
      else        err_q <= err_d;
   end

   always_comb err_d = err_q | ((state_q == S_NULL) && in_illegal);

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ula_ncl_seq.sv
// Bench for ula_ncl_seq: directed handshake steps plus random tokens vs an arithmetic model.
module tb_ula_ncl_seq;

   localparam int W = 5;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [2*W-1:0] a, b;
   logic [1:0]     sel0, sel1, carry_in;
   logic           ki, ko;
   logic [2*W-1:0] out_r;
   logic [1:0]     overflow, carry_out, neg, zero;
   logic           err;

   int n_cmp = 0;
   int n_err = 0;
   int av, bv, op, cin, gap;

   always #5 clk = ~clk;

   ula_ncl_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .a         (a),
      .b         (b),
      .sel0      (sel0),
      .sel1      (sel1),
      .carry_in  (carry_in),
      .ki        (ki),
      .ko        (ko),
      .out       (out_r),
      .overflow  (overflow),
      .carry_out (carry_out),
      .neg       (neg),
      .zero      (zero),
      .err       (err)
   );

   function automatic logic [1:0] r1(input int v);
      return (v != 0) ? 2'b10 : 2'b01;
   endfunction

   function automatic logic [2*W-1:0] enc(input int v);
      logic [2*W-1:0] e;
      for (int k = 0; k < W; k++) e[2*k +: 2] = r1((v >> k) & 1);
      return e;
   endfunction

   function automatic int sx(input int v);
      return (v >= (1 << (W-1))) ? v - (1 << W) : v;
   endfunction

   // Reference: plain integer arithmetic on the logical values.
   task automatic model(input int o, input int x, input int y, input int c,
                        output int r, output int ovf, output int cy);
      int s, ss;
      r = 0; ovf = 0; cy = 0;
      case (o)
         0: begin
            s  = x + y + c;
            ss = sx(x) + sx(y) + c;
            r  = s % (1 << W);
            cy = (s >= (1 << W)) ? 1 : 0;
            ovf = (ss > (1 << (W-1)) - 1 || ss < -(1 << (W-1))) ? 1 : 0;
         end
         1: begin
            s  = x + ((1 << W) - 1 - y) + c;
            ss = sx(x) - sx(y) - (1 - c);
            r  = s % (1 << W);
            cy = (s >= (1 << W)) ? 1 : 0;
            ovf = (ss > (1 << (W-1)) - 1 || ss < -(1 << (W-1))) ? 1 : 0;
         end
         2: r = x ^ y;
         default: r = x | y;
      endcase
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_token(input int x, input int y, input int o, input int c, input logic k);
      a = enc(x);
      b = enc(y);
      sel0 = r1(o & 1);
      sel1 = r1((o >> 1) & 1);
      carry_in = r1(c);
      ki = k;
   endtask

   task automatic drive_null(input logic k);
      a = '0; b = '0; sel0 = 2'b00; sel1 = 2'b00; carry_in = 2'b00;
      ki = k;
   endtask

   task automatic check_null(input string tag);
      chk({tag, ".out"}, 32'(out_r), 32'd0);
      chk({tag, ".flags"}, 32'({overflow, carry_out, neg, zero}), 32'd0);
      chk({tag, ".ko"}, 32'(ko), 32'd1);
   endtask

   task automatic check_data(input string tag, input int o, input int x, input int y, input int c);
      int r, ovf, cy;
      model(o, x, y, c, r, ovf, cy);
      chk({tag, ".out"}, 32'(out_r), 32'(enc(r)));
      chk({tag, ".ovf"}, 32'(overflow), 32'(r1(ovf)));
      chk({tag, ".cy"}, 32'(carry_out), 32'(r1(cy)));
      chk({tag, ".neg"}, 32'(neg), 32'(r1((r >> (W-1)) & 1)));
      chk({tag, ".zero"}, 32'(zero), 32'(r1(r == 0 ? 1 : 0)));
      chk({tag, ".ko"}, 32'(ko), 32'd0);
   endtask

   // Full DATA then NULL token with ki=1 already present.
   task automatic token(input string tag, input int o, input int x, input int y, input int c);
      drive_token(x, y, o, c, 1'b1);
      step();
      check_data(tag, o, x, y, c);
      drive_null(1'b0);
      step();
      check_null({tag, ".null"});
   endtask

   initial begin
      rst_n = 1'b0;
      drive_null(1'b0);
      #12;
      check_null("reset");
      chk("reset.err", 32'(err), 32'd0);
      rst_n = 1'b1;
      step();
      check_null("idle");

      token("add7p7", 0, 7, 7, 0);
      chk("add7p7.exp", 32'(out_r), 32'd0);
      drive_token(7, 7, 0, 0, 1'b1);
      step();
      chk("add7p7.lit", 32'(out_r), 32'(enc(14)));
      drive_null(1'b0);
      step();

      token("sub10m11", 1, 10, 11, 1);
      token("sub15mm15", 1, 15, 17, 0);
      token("add15p1", 0, 15, 1, 0);
      token("xor8_12", 2, 8, 12, 1);
      token("or_5_10", 3, 5, 10, 0);
      token("add_zero", 0, 16, 16, 0);

      // Complete inputs but consumer not ready: must wait.
      drive_token(3, 4, 0, 1, 1'b0);
      step();
      step();
      check_null("wait_ki");
      ki = 1'b1;
      step();
      check_data("ki_rise", 0, 3, 4, 1);

      b[9:8] = 2'b00;
      step();
      check_data("partial_hold", 0, 3, 4, 1);
      drive_token(20, 9, 3, 0, 1'b1);
      step();
      check_data("frozen", 0, 3, 4, 1);
      drive_null(1'b1);
      step();
      check_data("null_ki1", 0, 3, 4, 1);
      ki = 1'b0;
      step();
      check_null("null_ki0");

      // Partial inputs in S_NULL never launch a token.
      drive_token(9, 9, 0, 0, 1'b1);
      sel1 = 2'b00;
      step();
      check_null("partial_null");
      sel1 = r1(0);
      step();
      check_data("partial_done", 0, 9, 9, 0);

      // Asynchronous reset while holding DATA.
      #2;
      rst_n = 1'b0;
      #1;
      check_null("async_rst");
      drive_null(1'b0);
      #1;
      rst_n = 1'b1;
      step();
      check_null("post_rst");

`ifdef ULA_ILLEGAL_CHECK_EN
      drive_token(6, 2, 0, 0, 1'b1);
      a[1:0] = 2'b11;
      step();
      check_null("illegal_block");
      chk("illegal.err", 32'(err), 32'd1);
      drive_null(1'b0);
      step();
      token("after_illegal", 0, 6, 2, 0);
      chk("err_sticky", 32'(err), 32'd1);
`else
      drive_token(6, 2, 0, 0, 1'b1);
      a[1:0] = 2'b11;
      step();
      check_data("illegal_as_1", 0, 7, 2, 0);
      chk("illegal.err", 32'(err), 32'd0);
      drive_null(1'b0);
      step();
      check_null("illegal_null");
`endif

      for (int t = 0; t < 40; t++) begin
         op  = int'($urandom_range(3, 0));
         av  = int'($urandom_range(31, 0));
         bv  = int'($urandom_range(31, 0));
         cin = int'($urandom_range(1, 0));
         gap = int'($urandom_range(2, 0));
         drive_token(av, bv, op, cin, 1'b0);
         for (int g = 0; g < gap; g++) begin
            step();
            check_null("rnd_wait");
         end
         ki = 1'b1;
         step();
         check_data("rnd", op, av, bv, cin);
         drive_token(int'($urandom_range(31, 0)), bv, op, cin, 1'b1);
         step();
         check_data("rnd_hold", op, av, bv, cin);
         drive_null(1'b0);
         step();
         check_null("rnd_null");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
